// File: rtl/uart_rx_datapath_if.sv
// Received-byte stream between the UART Rx datapath (master) and its consumer (slave).
interface uart_rx_datapath_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_datapath.sv
// UART Rx datapath: LSB-first shifter, parity/stop checking, one-entry output buffer.
// Define UART_RX_ERR_COUNT_EN to add saturating parity/frame error counters.
module uart_rx_datapath #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               serial_in,
  input  logic               shift,
  input  logic               check_parity,
  input  logic               check_stop,
  output logic               parity_error,
  uart_rx_datapath_if.master rx,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overrun,
  input  logic               clear_status
`ifdef UART_RX_ERR_COUNT_EN
  ,
  output logic [7:0]         parity_err_count,
  output logic [7:0]         frame_err_count
`endif
);

  logic [DATA_BITS-1:0] shift_reg_r;
  logic                 par_acc_r;
  logic [DATA_BITS-1:0] shift_nxt_s;
  logic                 par_nxt_s;
  logic                 good_stop_s;
  logic                 bad_stop_s;
  logic                 par_fail_s;
  logic [DATA_BITS-1:0] data_nxt_s;
  logic                 valid_nxt_s;
  logic                 ovr_set_s;

  function automatic logic parity_mismatch(input logic acc, input logic bit_in);
    return acc ^ bit_in ^ PARITY_ODD;
  endfunction

  // The FSM samples this in the same cycle, so it must stay combinational.
  assign parity_error = check_parity & parity_mismatch(par_acc_r, serial_in);

  // Per-bit decode of the FSM strobes; stop outranks parity, parity outranks shift.
  always_comb begin
    shift_nxt_s = shift_reg_r;
    par_nxt_s   = par_acc_r;
    good_stop_s = 1'b0;
    bad_stop_s  = 1'b0;
    par_fail_s  = 1'b0;
    if (check_stop) begin
      good_stop_s = serial_in;
      bad_stop_s  = ~serial_in;
    end else if (check_parity) begin
      par_fail_s = parity_error;
    end else if (shift) begin
      shift_nxt_s = {serial_in, shift_reg_r[DATA_BITS-1:1]};
      par_nxt_s   = par_acc_r ^ serial_in;
    end else begin
      shift_nxt_s = {DATA_BITS{1'b0}};
      par_nxt_s   = 1'b0;
    end
  end

  // Output buffer: load when empty or popped this cycle, else drop the new byte.
  always_comb begin
    data_nxt_s  = rx.data;
    valid_nxt_s = rx.valid;
    ovr_set_s   = 1'b0;
    if (good_stop_s) begin
      if (!rx.valid || rx.ready) begin
        data_nxt_s  = shift_reg_r;
        valid_nxt_s = 1'b1;
      end else begin
        ovr_set_s = 1'b1;
      end
    end else if (rx.valid && rx.ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = rx.valid;
    end
  end

  // State and registered status outputs; an overrun event beats clear_status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg_r <= {DATA_BITS{1'b0}};
      par_acc_r   <= 1'b0;
      rx.data     <= {DATA_BITS{1'b0}};
      rx.valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      shift_reg_r <= shift_nxt_s;
      par_acc_r   <= par_nxt_s;
      rx.data     <= data_nxt_s;
      rx.valid    <= valid_nxt_s;
      parity_err  <= par_fail_s;
      frame_err   <= bad_stop_s;
      overrun     <= ovr_set_s | (overrun & ~clear_status);
    end
  end

`ifdef UART_RX_ERR_COUNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'd255) ? value : value + 8'd1;
  endfunction

  // Saturating error counters; clear_status wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_count <= 8'd0;
      frame_err_count  <= 8'd0;
    end else if (clear_status) begin
      parity_err_count <= 8'd0;
      frame_err_count  <= 8'd0;
    end else begin
      parity_err_count <= par_fail_s ? sat_inc(parity_err_count) : parity_err_count;
      frame_err_count  <= bad_stop_s ? sat_inc(frame_err_count) : frame_err_count;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Self-checking bench for uart_rx_datapath: an even-parity instance (main) and an odd one.
module tb_uart_rx_datapath;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b1;
  logic shift = 1'b0;
  logic check_parity = 1'b0;
  logic check_stop = 1'b0;
  logic clear_status = 1'b0;
  logic rx_ready = 1'b0;

  logic parity_error0, parity_err0, frame_err0, overrun0;
  logic parity_error1, parity_err1, frame_err1, overrun1;
`ifdef UART_RX_ERR_COUNT_EN
  logic [7:0] pcnt0, fcnt0, pcnt1, fcnt1;
  int exp_pcnt = 0;
  int exp_fcnt = 0;
`endif

  uart_rx_datapath_if #(.DATA_BITS(8)) rx0 ();
  uart_rx_datapath_if #(.DATA_BITS(8)) rx1 ();
  assign rx0.ready = rx_ready;
  assign rx1.ready = rx_ready;

  uart_rx_datapath #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift(shift),
    .check_parity(check_parity), .check_stop(check_stop),
    .parity_error(parity_error0), .rx(rx0.master), .parity_err(parity_err0),
    .frame_err(frame_err0), .overrun(overrun0), .clear_status(clear_status)
`ifdef UART_RX_ERR_COUNT_EN
    , .parity_err_count(pcnt0), .frame_err_count(fcnt0)
`endif
  );

  uart_rx_datapath #(.DATA_BITS(8), .PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift(shift),
    .check_parity(check_parity), .check_stop(check_stop),
    .parity_error(parity_error1), .rx(rx1.master), .parity_err(parity_err1),
    .frame_err(frame_err1), .overrun(overrun1), .clear_status(clear_status)
`ifdef UART_RX_ERR_COUNT_EN
    , .parity_err_count(pcnt1), .frame_err_count(fcnt1)
`endif
  );

  always #5 clk = ~clk;

  // At most one FSM strobe may be active in any bit period.
  always @(posedge clk) begin
    assert ($onehot0({shift, check_parity, check_stop}))
      else $error("illegal strobe combination");
  end

  typedef struct packed {
    logic [7:0] b;
    logic       par;
    logic       stop;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_good;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] sb [$];
  logic [7:0] last_data = 8'h00;
  logic       last_pe0, last_pe1;
  int         errors = 0;
  int         checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one bit period; captures combinational outputs and scores popped bytes.
  task automatic drive(input logic s, input logic sh, input logic cp, input logic cs);
    serial_in = s; shift = sh; check_parity = cp; check_stop = cs;
    #1;
    last_pe0 = parity_error0;
    last_pe1 = parity_error1;
    if (rx0.valid && rx_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got %02h expected none", rx0.data);
      end else begin
        chk8("rx_data_pop", rx0.data, sb.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) drive(b[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    chk1("rx_valid_after_pop", rx0.valid, 1'b0);
  endtask

  task automatic check_counts();
`ifdef UART_RX_ERR_COUNT_EN
    chk8("parity_err_count", pcnt0, 8'(exp_pcnt));
    chk8("frame_err_count", fcnt0, 8'(exp_fcnt));
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic exp_pe, input logic keep,
                            input logic rdy_stop, input logic clr_stop);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_byte(b);
    drive(par, 1'b0, 1'b1, 1'b0);
    chk1("parity_error", last_pe0, exp_pe);
    if (exp_pe) begin
      chk1("parity_err_pulse", parity_err0, 1'b1);
`ifdef UART_RX_ERR_COUNT_EN
      if (exp_pcnt < 255) exp_pcnt++;
`endif
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk1("parity_err_end", parity_err0, 1'b0);
    end else begin
      chk1("parity_err_quiet", parity_err0, 1'b0);
      if (keep) sb.push_back(b);
      rx_ready = rdy_stop;
      clear_status = clr_stop;
      drive(stop, 1'b0, 1'b0, 1'b1);
      rx_ready = 1'b0;
      clear_status = 1'b0;
      chk1("frame_err_pulse", frame_err0, ~stop);
      if (stop && keep) last_data = b;
`ifdef UART_RX_ERR_COUNT_EN
      if (clr_stop) begin
        exp_pcnt = 0;
        exp_fcnt = 0;
      end else if (!stop && exp_fcnt < 255) begin
        exp_fcnt++;
      end
`endif
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk1("frame_err_end", frame_err0, 1'b0);
    end
  endtask

  initial begin
    // byte, parity bit, stop bit, parity_error, frame_err, buffered (even parity)
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h37, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    @(negedge clk);
    @(negedge clk);
    chk8("reset_rx_data", rx0.data, 8'h00);
    chk1("reset_rx_valid", rx0.valid, 1'b0);
    chk1("reset_parity_err", parity_err0, 1'b0);
    chk1("reset_frame_err", frame_err0, 1'b0);
    chk1("reset_overrun", overrun0, 1'b0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].b, vecs[i].par, vecs[i].stop, vecs[i].exp_pe,
                 vecs[i].exp_good, 1'b0, 1'b0);
      chk1("rx_valid_after_frame", rx0.valid, vecs[i].exp_good);
      chk8("rx_data_held", rx0.data, last_data);
      check_counts();
      if (vecs[i].exp_good) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk1("rx_valid_hold", rx0.valid, 1'b1);
        pop_one();
        chk8("rx_data_after_pop", rx0.data, last_data);
      end
    end

    // Overrun, set-beats-clear, then clear and pop.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk8("overrun_keeps_old", rx0.data, 8'h11);
    chk1("overrun_set", overrun0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk1("overrun_set_wins", overrun0, 1'b1);
    check_counts();
    clear_status = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    clear_status = 1'b0;
    chk1("overrun_cleared", overrun0, 1'b0);
    pop_one();

    // Pop and load on the same edge.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk8("pop_load_data", rx0.data, 8'h22);
    chk1("pop_load_valid", rx0.valid, 1'b1);
    chk1("pop_load_no_overrun", overrun0, 1'b0);
    pop_one();

    // Reset part way through a frame of 0xFF.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk8("midreset_rx_data", rx1.data, 8'h00);
    chk1("midreset_rx_valid", rx1.valid, 1'b0);
    chk1("midreset_overrun", overrun1, 1'b0);
    chk1("midreset_perr", parity_err1, 1'b0);
    chk1("midreset_ferr", frame_err1, 1'b0);
    chk8("midreset_rx_data0", rx0.data, 8'h00);
    sb.delete();
`ifdef UART_RX_ERR_COUNT_EN
    exp_pcnt = 0;
    exp_fcnt = 0;
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // 0x5A with odd parity bit 1: good on the odd instance, a parity failure on the even one.
    shift_byte(8'h5A);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk1("odd_parity_ok", last_pe1, 1'b0);
    chk1("even_sees_mismatch", last_pe0, 1'b1);
`ifdef UART_RX_ERR_COUNT_EN
    exp_pcnt++;
`endif
    chk1("odd_no_perr", parity_err1, 1'b0);
    sb.push_back(8'h5A);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk8("odd_rx_data", rx1.data, 8'h5A);
    chk1("odd_rx_valid", rx1.valid, 1'b1);
    chk1("odd_no_ferr", frame_err1, 1'b0);
    chk1("odd_no_overrun", overrun1, 1'b0);
    check_counts();
    pop_one();
    chk1("odd_valid_after_pop", rx1.valid, 1'b0);
    chk1("scoreboard_drained", sb.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_datapath.md
Name: uart_rx_datapath

Overview:
Receive datapath driven by the UART Rx control FSM, clocked once per bit period.
- Shifts serial data in LSB-first, accumulates parity and returns the combinational parity_error the FSM needs during its parity cycle.
- Checks the stop bit and holds each good byte in a one-entry output buffer with a valid/ready handshake.
- Reports parity, framing and overrun errors.

Parameters:
DATA_BITS, 8, bits per frame; must equal the FSM data count (8); other values unsupported.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
clk  in  1  bit-rate clock shared with the Rx FSM
reset  in  1  asynchronous, active-high reset
serial_in  in  1  synchronised Rx line, valid for the current bit period
shift  in  1  FSM strobe: current bit is a data bit
check_parity  in  1  FSM strobe: current bit is the parity bit
check_stop  in  1  FSM strobe: current bit is the stop bit
parity_error  out  1  combinational parity mismatch, fed back to FSM
rx_data  out  DATA_BITS  buffered received byte
rx_valid  out  1  rx_data holds an unread byte
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
parity_err  out  1  registered one-cycle pulse per parity-failed frame
frame_err  out  1  registered one-cycle pulse per frame with stop bit = 0
overrun  out  1  sticky: a good byte was lost because the buffer was full
clear_status  in  1  synchronous clear of overrun (and counters if present)

Behaviour:
- Reset (async, active-high): shift_reg=0, par_acc=0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0.
- Idle cycle (shift, check_parity, check_stop all 0): shift_reg<=0, par_acc<=0. The FSM always passes idle before data, so every frame starts clean.
- Shift cycle: shift_reg<={serial_in, shift_reg[DATA_BITS-1:1]}; par_acc<=par_acc^serial_in. After 8 shifts, the first bit received sits at bit 0.
- Parity cycle: parity_error = check_parity & (par_acc ^ serial_in ^ PARITY_ODD). It is purely combinational, so the FSM samples it in the same cycle. parity_error=0 whenever check_parity=0.
  - If parity_error=1: parity_err=1 next cycle for exactly one cycle; byte discarded; the FSM returns to idle.
- Stop cycle, serial_in=1: good byte; load shift_reg into the buffer at the clock edge (rules below).
- Stop cycle, serial_in=0: frame_err=1 next cycle for one cycle; byte discarded; buffer untouched.
- Buffer load at a good stop edge (priority order):
  - rx_valid=0: rx_data<=shift_reg, rx_valid<=1. Latency: rx_valid rises the cycle after the stop cycle.
  - rx_valid=1 & rx_ready=1 (simultaneous pop and load): rx_data<=shift_reg, rx_valid stays 1, no overrun.
  - rx_valid=1 & rx_ready=0: old byte kept, new byte dropped, overrun<=1.
- Pop without load: rx_valid & rx_ready -> rx_valid<=0; rx_data holds its last value.
- clear_status: overrun<=0 at the next edge. If an overrun event occurs in the same cycle, set wins and overrun stays 1.
- More than one strobe high in a cycle is illegal. Priority is check_stop > check_parity > shift; a bench assertion flags it.
- Reset mid-frame: all state clears immediately and any partial byte is lost. The next frame is received normally once the FSM leaves idle.

Optional Feature:
UART_RX_ERR_COUNT_EN
- Defined: adds outputs parity_err_count[7:0] and frame_err_count[7:0].
  - Each increments on its error pulse event and saturates at 255.
  - Both cleared by reset and by clear_status. Clear wins over a simultaneous increment.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Even parity, byte 0xA5: serial bits 1,0,1,0,0,1,0,1; parity 0; stop 1; rx_ready=0 -> parity_error=0 in parity cycle; next cycle after stop, rx_data=0xA5, rx_valid=1; hold until rx_ready=1, then rx_valid=0 next cycle.
2. 0xA5 with parity bit 1 -> parity_error=1 combinationally in the parity cycle; parity_err pulses once next cycle; rx_valid stays 0; with the counter macro, parity_err_count=1.
3. 0x3C, parity 0, stop 0 -> frame_err pulses for one cycle; rx_valid=0; buffer unchanged.
4. Overrun: receive 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1. Then assert clear_status -> overrun=0. Pop with rx_ready -> rx_valid=0.
5. Simultaneous pop and load: rx_data=0x11 valid, rx_ready=1 on 0x22's stop edge -> rx_data=0x22, rx_valid=1, overrun=0.
6. Reset after 4 data bits of 0xFF, then full frame 0x5A with PARITY_ODD=1 (parity bit 1) -> all outputs 0 during reset; next result is rx_data=0x5A, no errors.
